// File: rtl/tl_sensor_cond.sv
// Traffic-light sensor front end: per-road synchronizer, debounce qualifier,
// gap-hold extender and saturating arrival counter.

module tl_sensor_chan #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             raw,
    input  logic             cnt_clr,
    output logic             t,
    output logic [CNT_W-1:0] cnt
);
    typedef enum logic [1:0] {
        ST_ABSENT  = 2'd0,
        ST_QUAL    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    localparam logic [7:0]       DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       rc_q, rc_d;
    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             t_q, t_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arrive;

    // The synchronizer free-runs; only the FSM is gated by tick.
    always_comb begin
        meta_d = raw;
        sync_d = meta_q;
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        arrive  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_ABSENT: begin
                    if (sync_q) begin
                        state_d = ST_QUAL;
                        rc_d    = 8'd1;
                    end
                end
                ST_QUAL: begin
                    if (!sync_q) begin
                        state_d = ST_ABSENT;
                        rc_d    = 8'd0;
                    end else if (rc_q == DEB_LAST) begin
                        state_d = ST_PRESENT;
                        rc_d    = 8'd0;
                        arrive  = 1'b1;
                    end else begin
                        rc_d = rc_q + 8'd1;
                    end
                end
                ST_PRESENT: begin
                    // A one-sample hold window means the first low sample ends presence.
                    if (!sync_q) begin
                        if (HOLD_CYCLES == 1) begin
                            state_d = ST_ABSENT;
                            rc_d    = 8'd0;
                        end else begin
                            state_d = ST_HOLD;
                            rc_d    = 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (sync_q) begin
                        state_d = ST_PRESENT;
                        rc_d    = 8'd0;
                    end else if (rc_q == HOLD_LAST) begin
                        state_d = ST_ABSENT;
                        rc_d    = 8'd0;
                    end else begin
                        rc_d = rc_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_ABSENT;
                    rc_d    = 8'd0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle arrival; the count never wraps.
    always_comb begin
        t_d   = (state_d == ST_PRESENT) || (state_d == ST_HOLD);
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (arrive && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= ST_ABSENT;
            rc_q    <= 8'd0;
            t_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            state_q <= state_d;
            rc_q    <= rc_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
        end
    end

    assign t   = t_q;
    assign cnt = cnt_q;
endmodule

module tl_sensor_cond #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             sa_raw,
    input  logic             sb_raw,
    input  logic             cnt_clr,
    output logic             Ta,
    output logic             Tb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    tl_sensor_chan #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_chan_a (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .raw    (sa_raw),
        .cnt_clr(cnt_clr),
        .t      (Ta),
        .cnt    (cnt_a)
    );

    tl_sensor_chan #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_chan_b (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .raw    (sb_raw),
        .cnt_clr(cnt_clr),
        .t      (Tb),
        .cnt    (cnt_b)
    );
endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: directed vector table, hand sequences for latency,
// tick gating, saturation and async reset, plus random traffic against a run-length model.

module tb_tl_sensor_cond;
    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             tick = 1'b0;
    logic             sa_raw = 1'b0;
    logic             sb_raw = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             Ta, Tb;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    tl_sensor_cond #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .sa_raw(sa_raw), .sb_raw(sb_raw),
        .cnt_clr(cnt_clr), .Ta(Ta), .Tb(Tb), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: traffic is present once DEB consecutive ticked high
    // samples are seen, and ends after HOLD consecutive ticked low samples.
    bit m_raw1[2], m_raw2[2], m_pres[2];
    int m_hi[2], m_lo[2], m_cnt[2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                m_raw1[c] = 0; m_raw2[c] = 0; m_pres[c] = 0;
                m_hi[c] = 0; m_lo[c] = 0; m_cnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit s, arr, rnow;
                s = m_raw2[c];
                arr = 0;
                rnow = (c == 0) ? sa_raw : sb_raw;
                if (tick) begin
                    if (s) begin m_hi[c]++; m_lo[c] = 0; end
                    else   begin m_lo[c]++; m_hi[c] = 0; end
                    if (!m_pres[c] && m_hi[c] >= DEB) begin
                        m_pres[c] = 1; arr = 1;
                    end else if (m_pres[c] && m_lo[c] >= HOLD) begin
                        m_pres[c] = 0;
                    end
                end
                if (cnt_clr) m_cnt[c] = 0;
                else if (arr && m_cnt[c] < CMAX) m_cnt[c]++;
                m_raw2[c] = m_raw1[c];
                m_raw1[c] = rnow;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("model_Ta", 32'(Ta), 32'(m_pres[0]));
            chk("model_Tb", 32'(Tb), 32'(m_pres[1]));
            chk("model_cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
            chk("model_cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
        end
    end

    typedef struct {
        logic       sa, sb, tk, clr;
        int         n;
        logic       ta, tb;
        logic [7:0] ca, cb;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 3,  1'b0, 1'b0, 8'd0, 8'd0}; // short glitch
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 12, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b0, 8'd0, 8'd0}; // edge 5: not yet
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b0, 8'd1, 8'd0}; // edge 6: rises
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 5,  1'b1, 1'b0, 8'd1, 8'd0}; // gap bridged
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 4,  1'b1, 1'b0, 8'd1, 8'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 9,  1'b1, 1'b0, 8'd1, 8'd0}; // edge 9: held
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 8'd1, 8'd0}; // edge 10: falls
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 6,  1'b0, 1'b1, 8'd1, 8'd1};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 12, 1'b0, 1'b0, 8'd1, 8'd1};

        // Reset held while raw lines toggle
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sa_raw = 1'($urandom_range(0, 1));
            sb_raw = 1'($urandom_range(0, 1));
            tick = 1'b1;
            step(1);
            chk("rst_Ta", 32'(Ta), 0);
            chk("rst_Tb", 32'(Tb), 0);
            chk("rst_cnt_a", 32'(cnt_a), 0);
            chk("rst_cnt_b", 32'(cnt_b), 0);
        end
        sa_raw = 1'b0; sb_raw = 1'b0;
        reset_n = 1'b1;
        step(4);
        chk("post_rst_Ta", 32'(Ta), 0);
        chk("post_rst_cnt_a", 32'(cnt_a), 0);
        chk_en = 1'b1;

        // Debounce and gap-hold vector table
        for (int i = 0; i < 10; i++) begin
            sa_raw = vecs[i].sa; sb_raw = vecs[i].sb;
            tick = vecs[i].tk; cnt_clr = vecs[i].clr;
            step(vecs[i].n);
            chk($sformatf("vec%0d_Ta", i), 32'(Ta), 32'(vecs[i].ta));
            chk($sformatf("vec%0d_Tb", i), 32'(Tb), 32'(vecs[i].tb));
            chk($sformatf("vec%0d_cnt_a", i), 32'(cnt_a), 32'(vecs[i].ca));
            chk($sformatf("vec%0d_cnt_b", i), 32'(cnt_b), 32'(vecs[i].cb));
        end

        // Tick gating: only ticked samples advance the qualifier
        tick = 1'b0; sb_raw = 1'b1;
        step(20);
        chk("gate_no_tick_Tb", 32'(Tb), 0);
        for (int k = 1; k <= 4; k++) begin
            step(3);
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            chk($sformatf("gate_tick%0d_Tb", k), 32'(Tb), (k == 4) ? 32'd1 : 32'd0);
        end
        chk("gate_cnt_b", 32'(cnt_b), 2);
        sb_raw = 1'b0; tick = 1'b1;
        step(12);
        chk("gate_fall_Tb", 32'(Tb), 0);

        // Saturation of the arrival counter
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        chk("clr_cnt_a", 32'(cnt_a), 0);
        for (int p = 0; p < CMAX; p++) begin
            sa_raw = 1'b1; step(6);
            sa_raw = 1'b0; step(12);
        end
        chk("sat_255_cnt_a", 32'(cnt_a), CMAX);
        sa_raw = 1'b1; step(6);
        sa_raw = 1'b0; step(12);
        chk("sat_hold_cnt_a", 32'(cnt_a), CMAX);

        // Clear colliding with an arrival edge
        sa_raw = 1'b1;
        step(5);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        chk("clr_collide_Ta", 32'(Ta), 1);
        chk("clr_collide_cnt_a", 32'(cnt_a), 0);

        // Asynchronous reset while in the hold window
        sa_raw = 1'b0;
        step(3);
        chk("hold_Ta", 32'(Ta), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_Ta", 32'(Ta), 0);
        chk("async_rst_cnt_a", 32'(cnt_a), 0);
        chk("async_rst_cnt_b", 32'(cnt_b), 0);
        sa_raw = 1'b1;
        step(2);
        reset_n = 1'b1;
        step(5);
        chk("rerise_edge5_Ta", 32'(Ta), 0);
        step(1);
        chk("rerise_edge6_Ta", 32'(Ta), 1);
        chk("rerise_cnt_a", 32'(cnt_a), 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) sa_raw = ~sa_raw;
            if ($urandom_range(0, 6) == 0) sb_raw = ~sb_raw;
            tick = (i < 1500) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            cnt_clr = 1'($urandom_range(0, 149) == 0);
            step(1);
        end
        cnt_clr = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
